// File: rtl/serial_xor_cipher_ctrl.sv
// rtl/serial_xor_cipher_ctrl.sv - serial key/message loader, chunked XOR encrypt and MSB-first ciphertext sender
module serial_xor_cipher_ctrl #(
    parameter int KEY_W = 8,
    parameter int MSG_W = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic serial_in,
    input  logic key_load,
    input  logic msg_load,
    output logic serial_out,
    output logic out_valid,
    output logic busy,
    output logic key_valid,
    output logic err
);
    localparam int CNT_W   = $clog2(MSG_W) + 1;
    localparam int N_CHUNK = MSG_W / KEY_W;
    localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_W - 1);
    localparam logic [CNT_W-1:0] MSG_LAST   = CNT_W'(MSG_W - 1);
    localparam logic [CNT_W-1:0] CHUNK_LAST = CNT_W'(N_CHUNK - 1);

    typedef enum logic [2:0] {IDLE, LOAD_KEY, LOAD_MSG, ENCRYPT, SEND} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [KEY_W-1:0] key, key_sh, key_sh_nxt;
    logic [MSG_W-1:0] msg_reg, msg_shift, msg_xor;

    assign busy       = (state == ENCRYPT) || (state == SEND);
    assign key_sh_nxt = {key_sh[KEY_W-2:0], serial_in};
    assign msg_shift  = {msg_reg[MSG_W-2:0], serial_in};

    // XOR only the chunk selected by the counter during ENCRYPT
    always_comb begin
        msg_xor = msg_reg;
        for (int i = 0; i < N_CHUNK; i++) begin
            if (cnt == CNT_W'(i))
                msg_xor[i*KEY_W +: KEY_W] = msg_reg[i*KEY_W +: KEY_W] ^ key;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (key_load)      state_nxt = LOAD_KEY;
                else if (msg_load) state_nxt = LOAD_MSG;
            end
            LOAD_KEY: if (!key_load || cnt == KEY_LAST) state_nxt = IDLE;
            LOAD_MSG: begin
                if (!msg_load)            state_nxt = IDLE;
                else if (cnt == MSG_LAST) state_nxt = key_valid ? ENCRYPT : IDLE;
            end
            ENCRYPT:  if (cnt == CHUNK_LAST) state_nxt = SEND;
            SEND:     if (cnt == MSG_LAST) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Counter falls back to zero unless the current state keeps it counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            key        <= '0;
            key_sh     <= '0;
            msg_reg    <= '0;
            key_valid  <= 1'b0;
            err        <= 1'b0;
            serial_out <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            cnt <= '0;
            case (state)
                IDLE: begin
                    if (key_load) begin
                        key_sh <= key_sh_nxt;
                        err    <= 1'b0;
                        cnt    <= CNT_W'(1);
                    end else if (msg_load) begin
                        msg_reg <= msg_shift;
                        cnt     <= CNT_W'(1);
                    end
                end
                LOAD_KEY: begin
                    if (key_load) begin
                        key_sh <= key_sh_nxt;
                        err    <= 1'b0;
                        if (cnt == KEY_LAST) begin
                            key       <= key_sh_nxt;
                            key_valid <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                LOAD_MSG: begin
                    if (msg_load) begin
                        msg_reg <= msg_shift;
                        if (cnt == MSG_LAST) begin
                            if (!key_valid) err <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ENCRYPT: begin
                    msg_reg <= msg_xor;
                    if (cnt == CHUNK_LAST) begin
                        out_valid  <= 1'b1;
                        serial_out <= msg_xor[MSG_W-1];
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SEND: begin
                    msg_reg <= msg_reg << 1;
                    if (cnt == MSG_LAST) begin
                        out_valid  <= 1'b0;
                        serial_out <= 1'b0;
                    end else begin
                        cnt        <= cnt + CNT_W'(1);
                        serial_out <= msg_reg[MSG_W-2];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_xor_cipher_ctrl.sv
// tb/tb_serial_xor_cipher_ctrl.sv - self-checking bench for serial_xor_cipher_ctrl
module tb_serial_xor_cipher_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic serial_in = 1'b0, key_load = 1'b0, msg_load = 1'b0;
    logic serial_out, out_valid, busy, key_valid, err;

    int n_pass = 0;
    int n_tot  = 0;

    typedef struct {
        logic [7:0]  key;
        logic [63:0] msg;
        logic [63:0] ct;
    } vec_t;
    vec_t vecs[4];

    serial_xor_cipher_ctrl dut (
        .clk(clk), .rst(rst), .serial_in(serial_in), .key_load(key_load),
        .msg_load(msg_load), .serial_out(serial_out), .out_valid(out_valid),
        .busy(busy), .key_valid(key_valid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: every key-width byte of the message XORed with the key
    function automatic logic [63:0] model(input logic [63:0] m, input logic [7:0] k);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[b*8 +: 8] = m[b*8 +: 8] ^ k;
        return r;
    endfunction

    task automatic load_key(input logic [7:0] k, input int nb, input bit both);
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            key_load  = 1'b1;
            msg_load  = both;
            serial_in = k[7-i];
        end
        @(negedge clk);
        key_load = 1'b0; msg_load = 1'b0; serial_in = 1'b0;
    endtask

    task automatic send_msg(input logic [63:0] m, input int nb);
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            msg_load  = 1'b1;
            serial_in = m[63-i];
        end
        @(negedge clk);
        msg_load = 1'b0; serial_in = 1'b0;
    endtask

    // Called at the first negedge after the last message bit
    task automatic capture(input bit interfere, input int rst_after,
                           output logic [63:0] got, output int first_idx, output int nbits);
        got = '0; first_idx = -1; nbits = 0;
        for (int idx = 1; idx <= 120; idx++) begin
            if (out_valid) begin
                if (first_idx < 0) first_idx = idx;
                got = {got[62:0], serial_out};
                nbits++;
                if (nbits == rst_after) begin
                    rst = 1'b1;
                    #1;
                    check("rst_async_out_valid", 64'(out_valid), 64'd0);
                    check("rst_async_busy", 64'(busy), 64'd0);
                    check("rst_async_key_valid", 64'(key_valid), 64'd0);
                    break;
                end
            end else if (first_idx >= 0) begin
                check("busy_falls_with_out_valid", 64'(busy), 64'd0);
                break;
            end
            if (interfere) begin
                key_load  = 1'($urandom);
                msg_load  = 1'($urandom);
                serial_in = 1'($urandom);
            end
            @(negedge clk);
        end
        key_load = 1'b0; msg_load = 1'b0; serial_in = 1'b0;
    endtask

    task automatic full_msg(input string tag, input logic [63:0] m,
                            input logic [63:0] exp, input bit interfere);
        logic [63:0] got;
        int fi, nb;
        send_msg(m, 64);
        check({tag, "_busy_start"}, 64'(busy), 64'd1);
        capture(interfere, -1, got, fi, nb);
        check({tag, "_first_valid_cycle"}, 64'(fi), 64'd9);
        check({tag, "_nbits"}, 64'(nb), 64'd64);
        check({tag, "_ct"}, got, exp);
    endtask

    task automatic watch_quiet(input string tag, input int cycles);
        bit seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (busy || out_valid) seen = 1'b1;
            @(negedge clk);
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [63:0] got, m;
        logic [7:0] k;
        int fi, nb;

        vecs[0] = '{key: 8'hA5, msg: 64'hA3B1F9D2E7C6A594, ct: 64'h06145C7742630031};
        vecs[1] = '{key: 8'hFF, msg: 64'h0123456789ABCDEF, ct: 64'hFEDCBA9876543210};
        vecs[2] = '{key: 8'h3C, msg: 64'h0000000000000000, ct: 64'h3C3C3C3C3C3C3C3C};
        vecs[3] = '{key: 8'h00, msg: 64'hDEADBEEFCAFEF00D, ct: 64'hDEADBEEFCAFEF00D};

        #2 rst = 1'b1;
        @(negedge clk);
        check("reset_serial_out", 64'(serial_out), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_key_valid", 64'(key_valid), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        rst = 1'b0;

        // No key: message completes with err, nothing is sent
        send_msg(64'h1122334455667788, 64);
        watch_quiet("nokey_quiet", 80);
        check("nokey_err", 64'(err), 64'd1);
        check("nokey_key_valid", 64'(key_valid), 64'd0);
        load_key(8'h3C, 8, 1'b0);
        check("key_err_cleared", 64'(err), 64'd0);
        check("key_valid_set", 64'(key_valid), 64'd1);

        for (int i = 0; i < 4; i++) begin
            load_key(vecs[i].key, 8, 1'b0);
            full_msg($sformatf("vec%0d", i), vecs[i].msg, vecs[i].ct, 1'b0);
        end

        // Short key leaves the committed key in place
        load_key(8'hA5, 8, 1'b0);
        load_key(8'h5A, 5, 1'b0);
        check("short_key_valid", 64'(key_valid), 64'd1);
        full_msg("short_key", vecs[0].msg, vecs[0].ct, 1'b0);

        // Aborted message then full reload
        send_msg(vecs[0].msg, 30);
        watch_quiet("abort_quiet", 80);
        full_msg("abort_reload", vecs[0].msg, vecs[0].ct, 1'b0);

        // Strobe interference during ENCRYPT/SEND, then reuse the same key
        full_msg("interfere", 64'h0F1E2D3C4B5A6978, model(64'h0F1E2D3C4B5A6978, 8'hA5), 1'b1);
        full_msg("after_interfere", 64'h8877665544332211, model(64'h8877665544332211, 8'hA5), 1'b0);

        // Both strobes high in IDLE: key load wins; back-to-back key loads
        load_key(8'h11, 8, 1'b1);
        full_msg("both_strobes", 64'hCAFEBABE12345678, model(64'hCAFEBABE12345678, 8'h11), 1'b0);
        load_key(8'h22, 8, 1'b0);
        load_key(8'h77, 8, 1'b0);
        full_msg("b2b_key", 64'h0102030405060708, model(64'h0102030405060708, 8'h77), 1'b0);

        for (int r = 0; r < 6; r++) begin
            k = 8'($urandom);
            m = {$urandom, $urandom};
            load_key(k, 8, 1'b0);
            full_msg($sformatf("rand%0d", r), m, model(m, k), 1'($urandom));
        end

        // Reset mid-SEND after 20 bits
        load_key(8'h5C, 8, 1'b0);
        send_msg(64'hFEEDFACE01020304, 64);
        capture(1'b0, 20, got, fi, nb);
        check("rst_mid_bits", 64'(nb), 64'd20);
        @(negedge clk);
        rst = 1'b0;
        check("rst_err_clear", 64'(err), 64'd0);
        load_key(8'h96, 8, 1'b0);
        full_msg("post_rst", 64'hFEEDFACE01020304, model(64'hFEEDFACE01020304, 8'h96), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/serial_xor_cipher_ctrl.md
# serial_xor_cipher_ctrl

Sequencer for the serial XOR-cipher datapath. It deserialises an 8-bit key and a 64-bit message from a single serial pin under separate load strobes and encrypts the message byte-by-byte against the key. It then streams the ciphertext back out MSB-first with a valid flag. It sits between the chip's pin-mux (ui_in/uo_out bits) and the cipher registers, and owns all load/encrypt/transmit ordering.

## Interface
- KEY_W, 8: key width in bits; also the encryption chunk width.
- MSG_W, 64: message width in bits; must be an integer multiple of KEY_W.
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- serial_in  input  1  serial data, MSB first, sampled on each rising clk.
- key_load  input  1  high while key bits are presented.
- msg_load  input  1  high while message bits are presented.
- serial_out  output  1  ciphertext bit, registered, MSB first.
- out_valid  output  1  high while serial_out carries a ciphertext bit.
- busy  output  1  high in ENCRYPT and SEND.
- key_valid  output  1  a complete key has been committed since reset.
- err  output  1  sticky: message completed with no valid key; cleared by the next accepted key_load bit.

## Operation
- States: IDLE, LOAD_KEY, LOAD_MSG, ENCRYPT, SEND.
- IDLE:
  - key_load=1 -> LOAD_KEY; this cycle's bit is the first key bit.
  - Else msg_load=1 -> LOAD_MSG; this cycle's bit is the first message bit.
  - key_load has priority when both strobes are high.
- LOAD_KEY:
  - Shift serial_in into the key shadow register each cycle; the bit counter increments.
  - On the KEY_W-th bit, commit shadow to key, set key_valid, clear err, return to IDLE.
  - If key_load drops before KEY_W bits, discard the shadow, keep the previous key and key_valid, return to IDLE.
- LOAD_MSG:
  - Shift serial_in into msg_reg each cycle.
  - If msg_load drops before MSG_W bits: abort to IDLE, no output, counters cleared.
  - On the MSG_W-th bit: if key_valid, go to ENCRYPT; else set err and go to IDLE.
- ENCRYPT: one chunk per cycle, chunk index 0 (LSB byte) upward: msg_reg[i*KEY_W +: KEY_W] ^= key. Exits after MSG_W/KEY_W cycles to SEND.
- SEND: serial_out = msg_reg[MSG_W-1-n] for n = 0..MSG_W-1, with out_valid=1. Exits to IDLE after the last bit.
- key_load and msg_load are ignored in ENCRYPT and SEND, and when the non-owning strobe toggles during a load.
- Counter widths are clog2(MSG_W)+1. The bit counter resets on every state entry. No wrap-around is reachable.

## Timing
- Reset (async assert, registered deassert at the next edge): state=IDLE. serial_out, out_valid, busy, key_valid and err are all 0. Key, msg and counters are 0.
- Reset mid-operation aborts immediately. After release, a full key reload is required.
- Key load takes exactly KEY_W edges with key_load high. key_valid rises the cycle after the KEY_W-th sampled bit.
- Message: the last bit is sampled at edge N. busy is high from cycle N+1. ENCRYPT occupies MSG_W/KEY_W cycles (8 at default).
- out_valid rises at cycle N+1+MSG_W/KEY_W and stays high for exactly MSG_W consecutive cycles, with no gaps. The first bit is ciphertext[MSG_W-1].
- busy and out_valid fall together, the cycle after the last bit. IDLE accepts a new load strobe in that same cycle.
- Back-to-back: key_load high in the cycle after a key commit starts a new key load. There is no dead cycle.

## Test plan
- Basic: key A5, message A3B1F9D2E7C6A594 (MSB first) -> after 8 ENCRYPT cycles, out_valid high for 64 cycles; captured stream is 06145C7742630031.
- No key: reset, then load the message -> err=1, busy and out_valid never assert. Then load key 3C -> err=0, key_valid=1.
- Short key: load A5, then assert key_load for 5 bits only -> key stays A5. The next message encrypts with A5.
- Aborted message: drop msg_load after 30 bits -> state returns to IDLE, no out_valid. A full reload of the same message then produces the correct ciphertext.
- Interference: toggle key_load and msg_load throughout ENCRYPT/SEND -> the output stream is unchanged and the key is unchanged. Both strobes high in IDLE -> key load wins.
- Reset mid-SEND after 20 bits: out_valid=0, busy=0 and key_valid=0 asynchronously. A subsequent key plus message load runs cleanly.
